// File: rtl/quad_sweep_scheduler.sv
// quad_sweep_scheduler
//   Periodically sweeps NUM_CH 32-bit quadrature positions in round-robin order.
//   For each channel it computes the per-period velocity (position delta) with
//   one shared subtractor. Results are exposed through a 4-bit-address
//   Avalon-MM slave.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   pos                 NUM_CH packed signed positions (channel k at [32k+31:32k])
//   address/write/writedata/read/readdata/waitrequest
//                       Avalon-MM slave; reads take two cycles, writes take one
//   sample_tick         one-cycle pulse in the DONE cycle of each sweep
//   busy                high while a sweep is in progress
//
// Register map (word address)
//   0x0 CTRL  [0] ENABLE, [1] RESYNC (write-1, reads 0)
//   0x1 STATUS [31:8] sweep count, [1] overrun (write clears), [0] busy
//   0x2 PERIOD (clamped to >= 2*NUM_CH+2)
//   0x4+k VEL[k], 0x8+k LAST[k] (LAST readable only with the macro below)
//
// Optional feature
//   QUAD_SWEEP_SNAPSHOT_EN : makes LAST[k] readable at 0x8+k; otherwise those
//                            addresses read 32'hDEADBEEF.
module quad_sweep_scheduler #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
  parameter int unsigned SAMPLE_HZ     = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [32*NUM_CH-1:0] pos,
  input  logic [3:0]           address,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic                 read,
  output logic [31:0]          readdata,
  output logic                 waitrequest,
  output logic                 sample_tick,
  output logic                 busy
);

  localparam logic [31:0] PERIOD_RST = 32'(CLOCK_FREQ_HZ / SAMPLE_HZ);
  localparam logic [31:0] PERIOD_MIN = 32'(2 * NUM_CH + 2);
  localparam logic [1:0]  LAST_CH    = 2'(NUM_CH - 1);
  localparam logic [31:0] UNMAPPED   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, LATCH, DIFF, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] vel_q  [NUM_CH];
  logic [31:0] vel_d  [NUM_CH];
  logic [31:0] last_q [NUM_CH];
  logic [31:0] last_d [NUM_CH];
  logic [23:0] count_q, count_d;
  logic [1:0]  ch_q, ch_d;
  logic        enable_q, enable_d;
  logic        resync_pend_q, resync_pend_d;
  logic        resync_act_q, resync_act_d;
  logic        overrun_q, overrun_d;
  logic        rd_ack_q, rd_ack_d;
  logic        tc, start, wr_en, rd_start;
  logic [31:0] rdata;

  assign tc       = enable_q && (cnt_q >= period_q - 32'd1);
  assign start    = tc && (state_q == IDLE);
  assign wr_en    = write && !read;
  assign rd_start = read && !rd_ack_q;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tc) state_d = LATCH;
      LATCH:   state_d = DIFF;
      DIFF:    state_d = (ch_q == LAST_CH) ? DONE : LATCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sample_tick = (state_q == DONE);
    busy        = (state_q != IDLE);
    waitrequest = !rd_ack_q;
    readdata    = readdata_q;
  end

  // Datapath and control registers
  always_comb begin
    cnt_d         = '0;
    enable_d      = enable_q;
    period_d      = period_q;
    resync_pend_d = resync_pend_q;
    resync_act_d  = resync_act_q;
    overrun_d     = overrun_q;
    count_d       = count_q;
    ch_d          = ch_q;
    cur_d         = cur_q;
    vel_d         = vel_q;
    last_d        = last_q;

    if (enable_q && !tc) cnt_d = cnt_q + 32'd1;

    case (state_q)
      LATCH: begin
        for (int unsigned k = 0; k < NUM_CH; k++)
          if (ch_q == 2'(k)) cur_d = pos[32*k +: 32];
      end
      DIFF: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (ch_q == 2'(k)) begin
            vel_d[k]  = resync_act_q ? '0 : cur_q - last_q[k];
            last_d[k] = cur_q;
          end
        end
        ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 2'd1;
      end
      DONE: begin
        count_d      = count_q + 24'd1;
        resync_act_d = 1'b0;
      end
      default: ;
    endcase

    // A RESYNC request is armed for the whole of the next sweep that starts.
    if (start) begin
      resync_act_d  = resync_pend_q;
      resync_pend_d = 1'b0;
    end

    if (wr_en) begin
      case (address)
        4'h0: begin
          enable_d = writedata[0];
          if (writedata[1]) resync_pend_d = 1'b1;
        end
        4'h1:    overrun_d = 1'b0;
        4'h2:    period_d  = (writedata < PERIOD_MIN) ? PERIOD_MIN : writedata;
        default: ;
      endcase
    end

    // Terminal count during a sweep drops the request; setting wins over clear.
    if (tc && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // Read mux and two-cycle read handshake
  always_comb begin
    rdata = UNMAPPED;
    case (address)
      4'h0:    rdata = {31'd0, enable_q};
      4'h1:    rdata = {count_q, 6'd0, overrun_q, state_q != IDLE};
      4'h2:    rdata = period_q;
      default: ;
    endcase
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (address == 4'(4 + k)) rdata = vel_q[k];
`ifdef QUAD_SWEEP_SNAPSHOT_EN
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (address == 4'(8 + k)) rdata = last_q[k];
`endif
    rd_ack_d   = rd_start;
    readdata_d = rd_start ? rdata : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      period_q      <= PERIOD_RST;
      cur_q         <= '0;
      readdata_q    <= '0;
      count_q       <= '0;
      ch_q          <= '0;
      enable_q      <= 1'b0;
      resync_pend_q <= 1'b0;
      resync_act_q  <= 1'b0;
      overrun_q     <= 1'b0;
      rd_ack_q      <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        vel_q[k]  <= '0;
        last_q[k] <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      cur_q         <= cur_d;
      readdata_q    <= readdata_d;
      count_q       <= count_d;
      ch_q          <= ch_d;
      enable_q      <= enable_d;
      resync_pend_q <= resync_pend_d;
      resync_act_q  <= resync_act_d;
      overrun_q     <= overrun_d;
      rd_ack_q      <= rd_ack_d;
      vel_q         <= vel_d;
      last_q        <= last_d;
    end
  end

endmodule

// File: tb/tb_quad_sweep_scheduler.sv
// Testbench for quad_sweep_scheduler: randomized and directed stimulus checked
// against a sweep-level behavioural model, plus literal expectations.
module tb_quad_sweep_scheduler;
  localparam int N  = 4;
  localparam int SW = 2 * N;   // sweep cycle index of the DONE cycle

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [32*N-1:0] pos;
  logic [3:0]      address = '0;
  logic            write = 1'b0;
  logic [31:0]     writedata = '0;
  logic            read = 1'b0;
  logic [31:0]     readdata;
  logic            waitrequest, sample_tick, busy;

  logic [31:0] p [N];
  always_comb for (int k = 0; k < N; k++) pos[32*k +: 32] = p[k];

  quad_sweep_scheduler #(.NUM_CH(N), .CLOCK_FREQ_HZ(50_000_000), .SAMPLE_HZ(1000)) dut (
    .clk(clk), .reset_n(reset_n), .pos(pos), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .sample_tick(sample_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_s: index of the current cycle within a sweep (-1 when no sweep runs).
  bit          m_en, m_over, m_rpend, m_ract;
  logic [31:0] m_period, m_cnt, m_cur;
  logic [31:0] m_vel [N];
  logic [31:0] m_last [N];
  logic [23:0] m_count;
  int          m_s, m_sweeps, ms_nxt;
  bit          mtc, mwr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en = 0; m_over = 0; m_rpend = 0; m_ract = 0;
      m_period = 32'd50000; m_cnt = 0; m_cur = 0; m_count = 0; m_s = -1;
      for (int k = 0; k < N; k++) begin m_vel[k] = 0; m_last[k] = 0; end
    end else begin
      mtc = m_en && (m_cnt >= m_period - 32'd1);
      mwr = write && !read;
      ms_nxt = -1;
      if (m_s >= 0) begin
        if (m_s == SW) begin m_count++; m_sweeps++; m_ract = 0; end
        else if (m_s % 2 == 0) m_cur = p[m_s / 2];
        else begin
          m_vel[m_s / 2]  = m_ract ? 32'd0 : m_cur - m_last[m_s / 2];
          m_last[m_s / 2] = m_cur;
        end
        if (m_s < SW) ms_nxt = m_s + 1;
      end
      if (mwr && address == 4'h1) m_over = 0;
      if (mtc) begin
        if (m_s < 0) begin ms_nxt = 0; m_ract = m_rpend; m_rpend = 0; end
        else m_over = 1;
      end
      m_cnt = (m_en && !mtc) ? m_cnt + 32'd1 : 32'd0;
      if (mwr) begin
        if (address == 4'h0) begin
          m_en = writedata[0];
          if (writedata[1]) m_rpend = 1;
        end else if (address == 4'h2) begin
          m_period = (writedata < 32'(2*N+2)) ? 32'(2*N+2) : writedata;
        end
      end
      m_s = ms_nxt;
    end
  end

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    int ai = int'(a);
    if (ai == 0) return {31'd0, m_en};
    if (ai == 1) return {m_count, 6'd0, m_over, m_s >= 0};
    if (ai == 2) return m_period;
    if (ai >= 4 && ai < 4 + N) return m_vel[ai - 4];
`ifdef QUAD_SWEEP_SNAPSHOT_EN
    if (ai >= 8 && ai < 8 + N) return m_last[ai - 8];
`endif
    return 32'hDEADBEEF;
  endfunction

  // Per-cycle comparison of the sweep outputs
  int tick_seen = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy", {31'd0, busy}, {31'd0, m_s >= 0});
      check("sample_tick", {31'd0, sample_tick}, {31'd0, m_s == SW});
      if (sample_tick) tick_seen++;
    end
  end

  // Ramp on channel 0: +3 every 100 cycles
  bit ramp_on = 0;
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (ramp_on && (cyc % 100 == 0)) p[0] = p[0] + 32'd3;
  end

  // ---------------- bus tasks ----------------
  task automatic do_read(input logic [3:0] a, output logic [31:0] got, output logic [31:0] exp);
    @(negedge clk);
    address = a; read = 1'b1;
    #1;
    check("wait_first", {31'd0, waitrequest}, 32'd1);
    exp = m_rd(a);
    @(negedge clk);
    check("wait_second", {31'd0, waitrequest}, 32'd0);
    got = readdata;
    @(negedge clk);
    read = 1'b0;
    #1;
    check("wait_after", {31'd0, waitrequest}, 32'd1);
  endtask

  task automatic rd_model(input logic [3:0] a);
    logic [31:0] g, e;
    do_read(a, g, e);
    check($sformatf("read_%0h", a), g, e);
  endtask

  task automatic rd_lit(input string name, input logic [3:0] a, input logic [31:0] lit);
    logic [31:0] g, e;
    do_read(a, g, e);
    check(name, g, lit);
    check({name, "_model"}, g, e);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_sweeps(input int n);
    int target = m_sweeps + n;
    int c = 0;
    while (m_sweeps < target && c < n * 200 + 100) begin @(negedge clk); c++; end
    if (m_sweeps < target) begin
      checks++; errors++;
      $display("FAIL wait_sweeps: got %0d sweeps required %0d", m_sweeps, target);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] g, e, s1, s2;
    int c;
    m_sweeps = 0;
    for (int k = 0; k < N; k++) p[k] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
    check("rst_sample_tick", {31'd0, sample_tick}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    for (int k = 0; k < N; k++) rd_lit("rst_vel", 4'(4 + k), 32'd0);
    rd_lit("rst_ctrl", 4'h0, 32'd0);
    rd_lit("rst_status", 4'h1, 32'd0);
    rd_lit("rst_period", 4'h2, 32'd50000);
    rd_lit("unmapped_3", 4'h3, 32'hDEADBEEF);
    rd_lit("unmapped_f", 4'hF, 32'hDEADBEEF);

    // ENABLE=0: no ticks over 10,000 cycles
    repeat (10000) @(negedge clk);
    check("idle_ticks", 32'(tick_seen), 32'd0);

    // PERIOD=100, ramp on channel 0
    do_write(4'h2, 32'd100);
    do_write(4'h0, 32'd1);
    ramp_on = 1;
    wait_sweeps(3);
    rd_lit("vel0_ramp", 4'h4, 32'd3);
    do_read(4'h1, s1, e);
    check("status_a", s1, e);
    repeat (997) @(negedge clk);
    do_read(4'h1, s2, e);
    check("status_b", s2, e);
    check("sweeps_per_1000", 32'(s2[31:8] - s1[31:8]), 32'd10);

    // Signed wrap on channel 2
    wait_sweeps(1);
    p[2] = 32'h7FFF_FFFE;
    wait_sweeps(1);
    p[2] = 32'h8000_0001;
    wait_sweeps(1);
    rd_lit("vel2_wrap", 4'h6, 32'd3);
`ifdef QUAD_SWEEP_SNAPSHOT_EN
    rd_lit("last2", 4'hA, 32'h8000_0001);
`else
    rd_lit("last2_hidden", 4'hA, 32'hDEADBEEF);
`endif

    // RESYNC while channel 1 jumps
    wait_sweeps(1);
    do_write(4'h0, 32'd3);
    p[1] = p[1] + 32'd1000;
    rd_lit("ctrl_resync_reads0", 4'h0, 32'd1);
    wait_sweeps(1);
    rd_lit("vel1_resync", 4'h5, 32'd0);
    p[1] = p[1] + 32'd5;
    wait_sweeps(1);
    rd_lit("vel1_after", 4'h5, 32'd5);
    rd_lit("vel0_still", 4'h4, 32'd3);

    // PERIOD clamp, no overrun
    do_write(4'h2, 32'd4);
    rd_lit("period_clamp", 4'h2, 32'd10);
    wait_sweeps(50);
    do_read(4'h1, g, e);
    check("no_overrun", {31'd0, g[1]}, 32'd0);
    check("status_model", g, e);

    // Randomized phase
    ramp_on = 0;
    for (int i = 0; i < 400; i++) begin
      int op;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0) p[k] = $urandom;
      op = $urandom_range(0, 11);
      if (op <= 5) rd_model(4'($urandom_range(0, 15)));
      else if (op == 6) do_write(4'h2, 32'($urandom_range(0, 40)));
      else if (op == 7) do_write(4'h0, {30'd0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0});
      else if (op == 8) do_write(4'h1, $urandom);
      else if (op == 9) do_write(4'($urandom_range(3, 15)), $urandom);
      else repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    for (int a = 0; a < 16; a++) rd_model(4'(a));

    // Reset mid-sweep
    do_write(4'h2, 32'd20);
    do_write(4'h0, 32'd1);
    c = 0;
    while (m_s != 3 && c < 200) begin @(negedge clk); c++; end
    if (m_s != 3) begin
      checks++; errors++;
      $display("FAIL midsweep_wait: got sweep index %0d required 3", m_s);
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_tick", {31'd0, sample_tick}, 32'd0);
    check("midrst_waitrequest", {31'd0, waitrequest}, 32'd1);
    check("midrst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) rd_lit("midrst_vel", 4'(4 + k), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
